// File: rtl/tdm_receive_frame_if.sv
// Parallel frame output of the TDM receiver: sample vector plus valid/ready handshake.
// The producer (receiver) drives through master; the consumer uses slave.
interface tdm_receive_frame_if #(
    parameter int OUT_WIDTH = 32,
    parameter int SLOTS     = 4
);
    logic [SLOTS-1:0][OUT_WIDTH-1:0] audio_out;
    logic                            audio_valid_out;
    logic                            audio_ready_in;

    modport master (output audio_out, output audio_valid_out, input audio_ready_in);
    modport slave  (input audio_out, input audio_valid_out, output audio_ready_in);
endinterface

// File: rtl/tdm_receive_frame.sv
// TDM serial-audio receiver: deserialises SLOTS sign-extended samples per WS frame.
// Latency: padding SCK edges after the last data bit, then 2 clk_in cycles to valid.
// Backpressure: a held frame is never overwritten; a frame completing while busy is dropped.
module tdm_receive_frame #(
    parameter int DATA_WIDTH  = 24,
    parameter int SLOT_WIDTH  = 32,
    parameter int SLOTS       = 4,
    parameter int OUT_WIDTH   = 32,
    parameter int SAMPLE_RISE = 1,
    parameter int DATA_DELAY  = 1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                sck_in,
    input  logic                ws_in,
    input  logic                sd_in,
    tdm_receive_frame_if.master aud,
    output logic                frame_err_out,
    output logic                overrun_out
);
    localparam int BCW = $clog2(SLOT_WIDTH + 1);
    localparam int SCW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(SLOT_WIDTH - 1);
    localparam logic [BCW-1:0] BIT_DATA  = BCW'(DATA_WIDTH);
    localparam logic [SCW-1:0] SLOT_LAST = SCW'(SLOTS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, ARMED} state_t;

    state_t                           state_q;
    logic [2:0]                       sck_q;
    logic [1:0]                       ws_q;
    logic [1:0]                       sd_q;
    logic                             ws_prev_q;
    logic [BCW-1:0]                   bit_cnt_q;
    logic [SCW-1:0]                   slot_cnt_q;
    logic [SLOTS-1:0][DATA_WIDTH-1:0] slot_q;
    logic [SLOTS-1:0][OUT_WIDTH-1:0]  audio_q;
    logic [SLOTS-1:0][OUT_WIDTH-1:0]  audio_d;
    logic                             valid_q;
    logic                             frame_err_q;
    logic                             overrun_q;

    logic           s_stb;
    logic           sync;
    logic           last_bit;
    logic           start;
    logic           shift_en;
    logic [SCW-1:0] shift_idx;

    // sck_q[2] is the previous synchronised level, so S lines up with ws_q[1]/sd_q[1]
    assign s_stb = (SAMPLE_RISE != 0) ? (sck_q[1] & ~sck_q[2]) : (~sck_q[1] & sck_q[2]);
    assign sync  = s_stb & ws_q[1] & ~ws_prev_q;

    assign last_bit = (bit_cnt_q == BIT_LAST) && (slot_cnt_q == SLOT_LAST);
    assign start    = sync && ((state_q == IDLE) || (state_q == ARMED) ||
                               ((state_q == SHIFT) && !last_bit));
    assign shift_en = s_stb && (start ? (DATA_DELAY == 0)
                                      : ((state_q == SHIFT) && (bit_cnt_q < BIT_DATA)));
    assign shift_idx = start ? '0 : slot_cnt_q;

    always_comb begin
        audio_d = '0;
        for (int i = 0; i < SLOTS; i++) begin
            audio_d[i] = OUT_WIDTH'($signed(slot_q[i]));
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            sck_q       <= '0;
            ws_q        <= '0;
            sd_q        <= '0;
            ws_prev_q   <= 1'b0;
            bit_cnt_q   <= '0;
            slot_cnt_q  <= '0;
            slot_q      <= '0;
            audio_q     <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sck_q       <= {sck_q[1:0], sck_in};
            ws_q        <= {ws_q[0], ws_in};
            sd_q        <= {sd_q[0], sd_in};
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            if (s_stb) begin
                ws_prev_q <= ws_q[1];
            end
            if (shift_en) begin
                slot_q[shift_idx] <= {slot_q[shift_idx][DATA_WIDTH-2:0], sd_q[1]};
            end
            if (valid_q && aud.audio_ready_in) begin
                valid_q <= 1'b0;
            end

            if (start) begin
                // A sync mid-frame abandons the partial frame and starts over on it
                frame_err_q <= (state_q == SHIFT);
                state_q     <= SHIFT;
                slot_cnt_q  <= '0;
                bit_cnt_q   <= (DATA_DELAY == 0) ? BCW'(1) : BCW'(0);
            end else begin
                case (state_q)
                    IDLE, ARMED: begin
                        if (s_stb) begin
                            state_q <= IDLE;
                        end
                    end
                    SHIFT: begin
                        if (s_stb) begin
                            if (bit_cnt_q == BIT_LAST) begin
                                bit_cnt_q <= '0;
                                if (slot_cnt_q == SLOT_LAST) begin
                                    slot_cnt_q <= '0;
                                    state_q    <= COMMIT;
                                end else begin
                                    slot_cnt_q <= slot_cnt_q + SCW'(1);
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BCW'(1);
                            end
                        end
                    end
                    COMMIT: begin
                        state_q <= ARMED;
                        if (!valid_q || aud.audio_ready_in) begin
                            audio_q <= audio_d;
                            valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign aud.audio_out       = audio_q;
    assign aud.audio_valid_out = valid_q;
    assign frame_err_out       = frame_err_q;
    assign overrun_out         = overrun_q;
endmodule

// File: tb/tb_tdm_receive_frame.sv
// Bench for tdm_receive_frame: two instances (24/32/4 rising-edge, delay 1 and
// 16/16/8 falling-edge, delay 0) fed serial frames, scored against a frame-level model.
module tb_tdm_receive_frame;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, sck_a, ws_a, sd_a, err_a, ovr_a;
    logic rst_b, sck_b, ws_b, sd_b, err_b, ovr_b;

    tdm_receive_frame_if #(.OUT_WIDTH(32), .SLOTS(4)) aud_a ();
    tdm_receive_frame_if #(.OUT_WIDTH(32), .SLOTS(8)) aud_b ();

    tdm_receive_frame #(
        .DATA_WIDTH(24), .SLOT_WIDTH(32), .SLOTS(4), .OUT_WIDTH(32),
        .SAMPLE_RISE(1), .DATA_DELAY(1)
    ) dut_a (
        .clk_in(clk), .rst_in(rst_a), .sck_in(sck_a), .ws_in(ws_a), .sd_in(sd_a),
        .aud(aud_a), .frame_err_out(err_a), .overrun_out(ovr_a)
    );

    tdm_receive_frame #(
        .DATA_WIDTH(16), .SLOT_WIDTH(16), .SLOTS(8), .OUT_WIDTH(32),
        .SAMPLE_RISE(0), .DATA_DELAY(0)
    ) dut_b (
        .clk_in(clk), .rst_in(rst_b), .sck_in(sck_b), .ws_in(ws_b), .sd_in(sd_b),
        .aud(aud_b), .frame_err_out(err_b), .overrun_out(ovr_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [127:0] q_a[$];
    logic [255:0] q_b[$];
    int err_a_seen = 0, ovr_a_seen = 0, err_b_seen = 0, ovr_b_seen = 0;
    int exp_err_a = 0, exp_ovr_a = 0;
    bit rdy_mode_a = 1'b0;
    bit done_b = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Frame-level reference: each slot sign-extended to 32 bits, slot i at bits [32i+31:32i]
    function automatic logic [127:0] model_a(input logic [23:0] d [4]);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = {{8{d[i][23]}}, d[i]};
        return r;
    endfunction

    function automatic logic [255:0] model_b(input logic [15:0] d [8]);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = {{16{d[i][15]}}, d[i]};
        return r;
    endfunction

    // Instance A: data changes with SCK low, sampled on the rising edge
    task automatic bit_a(input logic w, input logic d);
        sck_a = 1'b0; ws_a = w; sd_a = d;
        repeat (4) @(posedge clk);
        #1 sck_a = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Sync edge (no data), nbits of frame payload, then gap idle bits with ws low
    task automatic frame_a(input logic [23:0] d [4], input int nbits, input int gap);
        bit_a(1'b1, 1'($urandom));
        for (int k = 0; k < nbits; k++) begin
            int s, b;
            s = k / 32;
            b = k % 32;
            bit_a(1'b0, (b < 24) ? d[s][23-b] : 1'($urandom));
        end
        for (int g = 0; g < gap; g++) bit_a(1'b0, 1'($urandom));
    endtask

    // Instance B: data changes with SCK high, sampled on the falling edge; MSB on the sync edge
    task automatic bit_b(input logic w, input logic d);
        sck_b = 1'b1; ws_b = w; sd_b = d;
        repeat (4) @(posedge clk);
        #1 sck_b = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic frame_b(input logic [15:0] d [8], input int gap);
        for (int k = 0; k < 128; k++) bit_b(k == 0, d[k/16][15-(k%16)]);
        for (int g = 0; g < gap; g++) bit_b(1'b0, 1'($urandom));
    endtask

    task automatic rand_a(output logic [23:0] d [4]);
        for (int i = 0; i < 4; i++) d[i] = 24'($urandom);
    endtask

    task automatic drain_a(input string name);
        int t = 0;
        while ((q_a.size() != 0 || aud_a.audio_valid_out) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(name, 256'(q_a.size()), 256'(0));
    endtask

    // Consumers
    initial begin
        aud_a.audio_ready_in = 1'b0;
        forever begin
            @(posedge clk);
            #1 aud_a.audio_ready_in = rdy_mode_a ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    initial begin
        aud_b.audio_ready_in = 1'b0;
        forever begin
            @(posedge clk);
            #1 aud_b.audio_ready_in = 1'($urandom_range(0, 1));
        end
    end

    // Monitors: a frame is consumed when valid&ready is seen between edges
    initial begin
        forever begin
            @(negedge clk);
            if (err_a) err_a_seen++;
            if (ovr_a) ovr_a_seen++;
            if (err_b) err_b_seen++;
            if (ovr_b) ovr_b_seen++;
            if (aud_a.audio_valid_out && aud_a.audio_ready_in) begin
                if (q_a.size() == 0) begin
                    n_chk++;
                    $display("FAIL a_frame: got %h expected no frame", aud_a.audio_out);
                end else check("a_frame", aud_a.audio_out, q_a.pop_front());
            end
            if (aud_b.audio_valid_out && aud_b.audio_ready_in) begin
                if (q_b.size() == 0) begin
                    n_chk++;
                    $display("FAIL b_frame: got %h expected no frame", aud_b.audio_out);
                end else check("b_frame", aud_b.audio_out, q_b.pop_front());
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion expected completion");
        $fatal(1, "watchdog expired");
    end

    // Instance B stimulus
    initial begin
        logic [15:0] d [8];
        int t;
        rst_b = 1'b0; sck_b = 1'b1; ws_b = 1'b0; sd_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;
        for (int i = 0; i < 8; i++) d[i] = 16'h1000 + 16'(i);
        q_b.push_back(model_b(d));
        frame_b(d, 0);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) d[i] = 16'($urandom);
            q_b.push_back(model_b(d));
            frame_b(d, (f == 1) ? 0 : int'($urandom_range(1, 6)));
        end
        t = 0;
        while ((q_b.size() != 0 || aud_b.audio_valid_out) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("b_drain", 256'(q_b.size()), 256'(0));
        done_b = 1'b1;
    end

    // Instance A stimulus and summary
    initial begin
        logic [23:0] d [4];
        int t;
        rst_a = 1'b0; sck_a = 1'b0; ws_a = 1'b0; sd_a = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", aud_a.audio_valid_out, 256'(0));
        check("rst_audio", aud_a.audio_out, 256'(0));
        check("rst_err", err_a, 256'(0));
        check("rst_ovr", ovr_a, 256'(0));
        rst_a = 1'b1;

        // Held frame, then reset mid-way through the next one
        rand_a(d);
        q_a.push_back(model_a(d));
        frame_a(d, 128, 0);
        t = 0;
        while (!aud_a.audio_valid_out && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t1_valid", aud_a.audio_valid_out, 256'(1));
        check("t1_held", aud_a.audio_out, q_a[0]);
        rand_a(d);
        frame_a(d, 40, 0);
        @(negedge clk) rst_a = 1'b0;
        @(negedge clk) rst_a = 1'b1;
        q_a.delete();
        check("t1_rst_valid", aud_a.audio_valid_out, 256'(0));
        check("t1_rst_audio", aud_a.audio_out, 256'(0));
        for (int k = 0; k < 88; k++) bit_a(1'b0, 1'($urandom));
        rdy_mode_a = 1'b1;
        rand_a(d);
        q_a.push_back(model_a(d));
        frame_a(d, 128, 3);
        drain_a("t1_drain");

        // Nominal pattern, then random frames back-to-back or with idle gaps
        d[0] = 24'hA5A5A5; d[1] = 24'h800001; d[2] = 24'h7FFFFF; d[3] = 24'h000001;
        q_a.push_back(model_a(d));
        frame_a(d, 128, 0);
        for (int f = 0; f < 4; f++) begin
            rand_a(d);
            q_a.push_back(model_a(d));
            frame_a(d, 128, $urandom_range(0, 1) ? 0 : int'($urandom_range(1, 5)));
        end
        drain_a("t2_drain");

        // Short frame: resync after 70 bits
        rand_a(d);
        frame_a(d, 70, 0);
        exp_err_a++;
        rand_a(d);
        q_a.push_back(model_a(d));
        frame_a(d, 128, 2);
        drain_a("t3_drain");
        check("t3_err_count", 256'(err_a_seen), 256'(exp_err_a));

        // Backpressure across two frames
        rdy_mode_a = 1'b0;
        rand_a(d);
        q_a.push_back(model_a(d));
        frame_a(d, 128, 0);
        rand_a(d);
        frame_a(d, 128, 0);
        exp_ovr_a++;
        repeat (20) @(negedge clk);
        check("t4_ovr_count", 256'(ovr_a_seen), 256'(exp_ovr_a));
        check("t4_valid", aud_a.audio_valid_out, 256'(1));
        check("t4_held", aud_a.audio_out, q_a[0]);
        rdy_mode_a = 1'b1;
        drain_a("t4_drain");

        // Sync loss: long idle, then relock
        for (int k = 0; k < 20; k++) bit_a(1'b0, 1'($urandom));
        rand_a(d);
        q_a.push_back(model_a(d));
        frame_a(d, 128, 1);
        drain_a("t5_drain");
        check("t5_err_count", 256'(err_a_seen), 256'(exp_err_a));
        check("t5_ovr_count", 256'(ovr_a_seen), 256'(exp_ovr_a));

        t = 0;
        while (!done_b && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("b_done", 256'(done_b), 256'(1));
        check("b_err_count", 256'(err_b_seen), 256'(0));
        check("b_ovr_count", 256'(ovr_b_seen), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
